// File: rtl/sigmoid_unit_if.sv
// sigmoid_unit_if
// Bundles the two streaming handshakes of the sigmoid stage.
//   in_valid/in_ready/in_x          : Q8.8 signed pre-activation stream into the unit
//   out_valid/out_ready/out_y/out_sat: Q0.8 activation stream out of the unit
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; a producer holding valid high keeps its
// data unchanged until that transfer, and ready may depend combinationally on
// the consumer side but never on the same stream's valid.
// master = the neighbour driving samples in and taking results out;
// slave  = the sigmoid unit itself.
interface sigmoid_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_y;
   logic        out_sat;

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_y, out_sat
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_y, out_sat
   );
endinterface

// File: rtl/sigmoid_unit.sv
// sigmoid_unit
// Full-range sigmoid built on the half-range LUT rom (x >= 0, 0.1 grid, 0..6.0).
// Three pipeline stages with full backpressure, one sample per cycle:
//   S1 quantizes |x| to the LUT grid index k (0..60) and flags |x| >= 6.0,
//   S2 turns k into the rom address round(k*25.6),
//   S3 reads the rom and mirrors the result for negative inputs (1 - sigma).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset; empties the pipe
//   bus  - sigmoid_unit_if.slave: in_valid/in_ready/in_x, out_valid/out_ready/out_y/out_sat
module sigmoid_unit (
   input  logic           clk,
   input  logic           rst,
   sigmoid_unit_if.slave  bus
);

   // Stage valid bits and advance terms: a stage moves when it is empty or
   // the stage after it moves, so a full pipe can accept and emit on one edge.
   logic v1, v2, v3;
   logic adv1, adv2, adv3;

   assign adv3 = !v3 || bus.out_ready;
   assign adv2 = !v2 || adv3;
   assign adv1 = !v1 || adv2;

   // S1 quantize (combinational part)
   logic [16:0] mag;
   logic [20:0] mag10;
   logic [12:0] kraw;
   logic [5:0]  k_n;
   logic        sat_n;

   // 17 bits so that 0x8000 yields 32768 without wrapping.
   assign mag   = bus.in_x[15] ? (17'h10000 - {1'b0, bus.in_x}) : {1'b0, bus.in_x};
   assign mag10 = ({4'b0, mag} << 3) + ({4'b0, mag} << 1);
   // +128 before the shift rounds to the nearest grid index, ties upward.
   assign kraw  = 13'((mag10 + 21'd128) >> 8);
   assign k_n   = (kraw > 13'd60) ? 6'd60 : kraw[5:0];
   assign sat_n = (mag >= 17'h00600);

   logic       s1_sign, s1_sat;
   logic [5:0] s1_k;

   // S2 address: k*6554/256 rounded equals round(k*25.6) for all k in 0..60,
   // so only the rom's own case addresses are ever produced.
   logic [18:0] kx;
   logic [18:0] prod;
   logic [15:0] addr_n;

   assign kx     = {13'b0, s1_k};
   assign prod   = (kx << 12) + (kx << 11) + (kx << 8) + (kx << 7)
                 + (kx << 4) + (kx << 3) + (kx << 1);
   assign addr_n = 16'((prod + 19'd128) >> 8);

   logic        s2_sign, s2_sat;
   logic [15:0] s2_addr;

   // S3 lookup and symmetry
   logic [15:0] rom_data;
   logic [7:0]  unused_rom_hi;
   logic [7:0]  d;
   logic [7:0]  y_n;

   rom u_rom (
      .addr (s2_addr),
      .data (rom_data)
   );

   assign unused_rom_hi = rom_data[15:8];
   assign d             = rom_data[7:0];
   // sigma(-x) = 1 - sigma(x); d is never below 0x80 so this stays in 0x01..0x80.
   assign y_n           = s2_sign ? 8'(9'd256 - {1'b0, d}) : d;

   logic [7:0] y_q;
   logic       sat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_k    <= '0;
         s1_sat  <= 1'b0;
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_addr <= '0;
         s2_sat  <= 1'b0;
         v3      <= 1'b0;
         y_q     <= '0;
         sat_q   <= 1'b0;
      end else begin
         if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sign <= bus.in_x[15];
               s1_k    <= k_n;
               s1_sat  <= sat_n;
            end
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               s2_sign <= s1_sign;
               s2_addr <= addr_n;
               s2_sat  <= s1_sat;
            end
         end
         if (adv3) begin
            v3 <= v2;
            if (v2) begin
               y_q   <= y_n;
               sat_q <= s2_sat;
            end
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = v3;
   assign bus.out_y     = y_q;
   assign bus.out_sat   = sat_q;

endmodule

// rom
// Half-range sigmoid table: address is x in Q8.8 on the 0.1 grid
// (round(k*25.6), k = 0..60), data[7:0] = round(256*sigma(x)) capped at 0xFF.
//   addr - 16-bit grid address
//   data - 16-bit word; upper byte reserved (zero)
module rom (
   input  logic [15:0] addr,
   output logic [15:0] data
);
   always_comb begin
      data = 16'h0000;
      case (addr)
         16'd0:    data = 16'h0080;
         16'd26:   data = 16'h0086;
         16'd51:   data = 16'h008D;
         16'd77:   data = 16'h0093;
         16'd102:  data = 16'h0099;
         16'd128:  data = 16'h009F;
         16'd154:  data = 16'h00A5;
         16'd179:  data = 16'h00AB;
         16'd205:  data = 16'h00B1;
         16'd230:  data = 16'h00B6;
         16'd256:  data = 16'h00BB;
         16'd282:  data = 16'h00C0;
         16'd307:  data = 16'h00C5;
         16'd333:  data = 16'h00C9;
         16'd358:  data = 16'h00CD;
         16'd384:  data = 16'h00D1;
         16'd410:  data = 16'h00D5;
         16'd435:  data = 16'h00D8;
         16'd461:  data = 16'h00DC;
         16'd486:  data = 16'h00DF;
         16'd512:  data = 16'h00E1;
         16'd538:  data = 16'h00E4;
         16'd563:  data = 16'h00E6;
         16'd589:  data = 16'h00E9;
         16'd614:  data = 16'h00EB;
         16'd640:  data = 16'h00ED;
         16'd666:  data = 16'h00EE;
         16'd691:  data = 16'h00F0;
         16'd717:  data = 16'h00F1;
         16'd742:  data = 16'h00F3;
         16'd768:  data = 16'h00F4;
         16'd794:  data = 16'h00F5;
         16'd819:  data = 16'h00F6;
         16'd845:  data = 16'h00F7;
         16'd870:  data = 16'h00F8;
         16'd896:  data = 16'h00F8;
         16'd922:  data = 16'h00F9;
         16'd947:  data = 16'h00FA;
         16'd973:  data = 16'h00FA;
         16'd998:  data = 16'h00FB;
         16'd1024: data = 16'h00FB;
         16'd1050: data = 16'h00FC;
         16'd1075: data = 16'h00FC;
         16'd1101: data = 16'h00FD;
         16'd1126: data = 16'h00FD;
         16'd1152: data = 16'h00FD;
         16'd1178: data = 16'h00FD;
         16'd1203: data = 16'h00FE;
         16'd1229: data = 16'h00FE;
         16'd1254: data = 16'h00FE;
         16'd1280: data = 16'h00FE;
         16'd1306: data = 16'h00FE;
         16'd1331: data = 16'h00FF;
         16'd1357: data = 16'h00FF;
         16'd1382: data = 16'h00FF;
         16'd1408: data = 16'h00FF;
         16'd1434: data = 16'h00FF;
         16'd1459: data = 16'h00FF;
         16'd1485: data = 16'h00FF;
         16'd1510: data = 16'h00FF;
         16'd1536: data = 16'h00FF;
         default:  data = 16'h0000;
      endcase
   end
endmodule
